data_memory: RTL and testbench

- Word-addressed data RAM for the MIPS datapath, used as the load/store data memory.
- 2^ADDRSZ words of NBITS bits each.
- Synchronous write on the rising clock edge, combinational (zero-latency) read.
- Asynchronous active-low reset clears the whole array to zero.

---
 rtl/dmem_pkg.sv | 11 +
 rtl/data_memory_if.sv | 29 ++
 rtl/data_memory.sv | 35 +++
 tb/tb_data_memory.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared constants and word type for the MIPS data memory.
// Imported by the memory, its bus interface and the bench.
package dmem_pkg;

    localparam int DMEM_NBITS  = 32;
    localparam int DMEM_ADDRSZ = 5;
    localparam int DEPTH       = 1 << DMEM_ADDRSZ;

    typedef logic signed [DMEM_NBITS-1:0] dmem_word_t;

endpackage : dmem_pkg

// File: rtl/data_memory_if.sv
// Load/store bus between the datapath (master) and the data memory (slave).
// The address is shared by the read and write paths.
interface data_memory_if
    import dmem_pkg::*;
#(
    parameter int NBITS  = DMEM_NBITS,
    parameter int ADDRSZ = DMEM_ADDRSZ
);

    logic                     write_ena;
    logic        [ADDRSZ-1:0] addr;
    logic signed [NBITS-1:0]  data_wr;
    logic signed [NBITS-1:0]  data_rd;

    modport master (
        output write_ena,
        output addr,
        output data_wr,
        input  data_rd
    );

    modport slave (
        input  write_ena,
        input  addr,
        input  data_wr,
        output data_rd
    );

endinterface : data_memory_if

// File: rtl/data_memory.sv
// Word-addressed data RAM: synchronous write, combinational read.
// Asynchronous active-low reset clears every word.
module data_memory
    import dmem_pkg::*;
#(
    parameter int NBITS  = DMEM_NBITS,
    parameter int ADDRSZ = DMEM_ADDRSZ
) (
    input  logic          clk,
    input  logic          rst_n,
    data_memory_if.slave  bus
);

    localparam int WORDS = 1 << ADDRSZ;

    typedef logic signed [NBITS-1:0] word_t;

    word_t mem [WORDS];

    // NOTE: the array must read zero the instant rst_n falls, so it is built
    // from resettable flops rather than a RAM macro that has no clear port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.write_ena) begin
            mem[bus.addr] <= bus.data_wr;
        end
    end

    // No bypass: a same-address write shows up only after the clock edge.
    assign bus.data_rd = mem[bus.addr];

endmodule : data_memory

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: vector table for write/read pairs
// plus hand sequences for reset, combinational read and reset-during-write.
module tb_data_memory;
    import dmem_pkg::*;

    localparam int NB = DMEM_NBITS;
    localparam int AB = DMEM_ADDRSZ;

    logic clk;
    logic rst_n;

    data_memory_if #(.NBITS(NB), .ADDRSZ(AB)) dif ();

    data_memory #(.NBITS(NB), .ADDRSZ(AB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          we;
        logic [AB-1:0] addr;
        logic [NB-1:0] wdata;
        logic [NB-1:0] exp_before;
        logic [NB-1:0] exp_after;
    } vec_t;

    vec_t vecs[11];
    logic [NB-1:0] sb_q[$];
    int n_applied;
    int n_miss;

    // Scoreboard: expectation queued when the read address is driven.
    task automatic expect_rd(input logic [NB-1:0] exp);
        sb_q.push_back(exp);
    endtask

    task automatic check(input string name);
        logic [NB-1:0] exp;
        n_applied++;
        if (sb_q.size() == 0) begin
            n_miss++;
            $display("FAIL %s: scoreboard empty, got %h", name, dif.data_rd);
        end else begin
            exp = sb_q.pop_front();
            if (dif.data_rd !== exp) begin
                n_miss++;
                $display("FAIL %s: got %h, expected %h", name, dif.data_rd, exp);
            end
        end
    endtask

    task automatic read_at(input logic [AB-1:0] a, input logic [NB-1:0] exp, input string name);
        dif.addr = a;
        expect_rd(exp);
        #1;
        check(name);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_applied = 0;
        n_miss    = 0;
        vecs[0]  = '{1'b1, 5'd1,  32'd123,        32'd0,          32'd123};
        vecs[1]  = '{1'b0, 5'd0,  32'd0,          32'd0,          32'd0};
        vecs[2]  = '{1'b1, 5'd0,  32'd123,        32'd0,          32'd123};
        vecs[3]  = '{1'b0, 5'd1,  -32'sd5,        32'd123,        32'd123};
        vecs[4]  = '{1'b0, 5'd0,  -32'sd5,        32'd123,        32'd123};
        vecs[5]  = '{1'b1, 5'd3,  32'd7,          32'd0,          32'd7};
        vecs[6]  = '{1'b1, 5'd4,  32'hFFFF_FFFF,  32'd0,          32'hFFFF_FFFF};
        vecs[7]  = '{1'b1, 5'd31, 32'h7FFF_FFFF,  32'd0,          32'h7FFF_FFFF};
        vecs[8]  = '{1'b1, 5'd31, 32'h8000_0000,  32'h7FFF_FFFF,  32'h8000_0000};
        vecs[9]  = '{1'b1, 5'd0,  32'd42,         32'd123,        32'd42};
        vecs[10] = '{1'b0, 5'd31, 32'd0,          32'h8000_0000,  32'h8000_0000};

        rst_n         = 1'b1;
        dif.write_ena = 1'b0;
        dif.addr      = '0;
        dif.data_wr   = '0;

        // Reset pulse mid-cycle, away from any clock edge.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        read_at(5'd0, 32'd0, "reset_immediate");
        for (int a = 0; a < DEPTH; a++) begin
            read_at(AB'(a), 32'd0, $sformatf("reset_sweep_%0d", a));
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Table: check old value before the edge, new value after it.
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            dif.write_ena = vecs[i].we;
            dif.data_wr   = vecs[i].wdata;
            read_at(vecs[i].addr, vecs[i].exp_before, $sformatf("vec%0d_pre", i));
            @(posedge clk);
            expect_rd(vecs[i].exp_after);
            #1;
            check($sformatf("vec%0d_post", i));
        end
        dif.write_ena = 1'b0;

        // Cross-address checks after the table, no clocking between reads.
        @(negedge clk);
        read_at(5'd1,  32'd123,       "addr1_kept");
        read_at(5'd31, 32'h8000_0000, "addr31_no_alias");
        read_at(5'd0,  32'd42,        "addr0_no_alias");

        // Combinational read toggle inside one half cycle.
        @(negedge clk);
        read_at(5'd3, 32'd7,          "toggle_3a");
        read_at(5'd4, 32'hFFFF_FFFF,  "toggle_4");
        read_at(5'd3, 32'd7,          "toggle_3b");

        // Reset asserted while a write is pending across an edge.
        @(negedge clk);
        dif.write_ena = 1'b1;
        dif.data_wr   = 32'd99;
        dif.addr      = 5'd5;
        rst_n         = 1'b0;
        read_at(5'd31, 32'd0, "rst_mid_immediate");
        dif.addr = 5'd5;
        @(posedge clk);
        expect_rd(32'd0);
        #1;
        check("rst_mid_write_ignored");
        for (int a = 0; a < DEPTH; a += 3) begin
            read_at(AB'(a), 32'd0, $sformatf("rst_mid_sweep_%0d", a));
        end

        @(negedge clk);
        rst_n       = 1'b1;
        dif.addr    = 5'd5;
        dif.data_wr = 32'd99;
        @(posedge clk);
        expect_rd(32'd99);
        #1;
        check("post_reset_write");
        dif.write_ena = 1'b0;
        @(negedge clk);
        read_at(5'd31, 32'd0, "post_reset_other");

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule : tb_data_memory
